// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-N demultiplexer.
// Holds the default data width and channel count, the drop-counter width
// and its saturation value, and the helper that sizes the select port.
package demux_pkg;

  localparam int DEMUX_DW_DEF  = 8;
  localparam int DEMUX_NCH_DEF = 4;
  localparam int DROP_CNT_W    = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

  // Select width: clog2 of the channel count, never narrower than one bit.
  function automatic int sel_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry holding register for a single demux output channel.
// A load always wins over a drain in the same cycle, so a channel whose sink
// is continuously ready sustains one beat per clock.
module demux_chan_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          drain_ready,
  output logic          full,
  output logic [DW-1:0] data
);

  // Capture on load; release only on a drain that is not refilled in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (full && drain_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1xn_reg.sv
// Registered 1-to-NCH demultiplexer with per-channel one-entry buffers.
// Optional build macro DEMUX_BROADCAST_EN adds the a_bcast input, which loads
// one payload into every channel at once.
//
// Handshake: an input transfer happens on a clock edge where a_valid && a_ready;
// a channel transfer happens on an edge where o_valid[k] && o_ready[k].
// a_ready is combinational from a_sel, o_ready and the channel full flags and
// never depends on a_valid. Out-of-range selects are always accepted and dropped.
module demux_1xn_reg
  import demux_pkg::*;
#(
  parameter int DW  = DEMUX_DW_DEF,
  parameter int NCH = DEMUX_NCH_DEF,
  localparam int SW = sel_width(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef DEMUX_BROADCAST_EN
  input  logic                  a_bcast,
`endif
  input  logic [DW-1:0]         a_data,
  input  logic                  a_valid,
  input  logic [SW-1:0]         a_sel,
  output logic                  a_ready,
  output logic [NCH*DW-1:0]     o_data,
  output logic [NCH-1:0]        o_valid,
  input  logic [NCH-1:0]        o_ready,
  output logic                  err_sel,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [NCH-1:0] full;
  logic [NCH-1:0] chan_ready;
  logic [NCH-1:0] sel_hit;
  logic [NCH-1:0] load;
  logic           sel_oob;
  logic           bcast;
  logic           xfer;
  logic           drop;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = a_bcast;
`else
  assign bcast = 1'b0;
`endif

  // A channel can take a new beat when empty or when its current beat leaves this cycle.
  assign chan_ready = ~full | o_ready;

  // Decode the select into a one-hot channel hit plus an out-of-range flag.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < NCH; k++) begin
      sel_hit[k] = (a_sel == SW'(k));
    end
    sel_oob = (32'(a_sel) >= NCH);
  end

  // Input ready: all channels for broadcast, always for a drop, else the selected channel.
  always_comb begin
    a_ready = 1'b0;
    if (bcast) begin
      a_ready = &chan_ready;
    end else if (sel_oob) begin
      a_ready = 1'b1;
    end else begin
      a_ready = |(sel_hit & chan_ready);
    end
  end

  assign xfer = a_valid && a_ready;
  assign load = bcast ? {NCH{xfer}} : (sel_hit & {NCH{xfer}});
  assign drop = xfer && sel_oob && !bcast;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_chan
      demux_chan_reg #(
        .DW (DW)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .load        (load[g]),
        .load_data   (a_data),
        .drain_ready (o_ready[g]),
        .full        (full[g]),
        .data        (o_data[g*DW +: DW])
      );
    end
  endgenerate

  assign o_valid = full;

  // Flag each dropped beat for one cycle and keep a saturating tally of drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_sel <= drop;
      if (drop && (drop_cnt != DROP_CNT_MAX)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_1xn_reg.sv
// Testbench for demux_1xn_reg: a 4-channel instance for unicast, backpressure,
// streaming, reset and broadcast, plus a 3-channel instance for dropped selects.
// Channel outputs are compared by a monitor against an expected queue of
// {channel, data} entries pushed by the driver when a beat is accepted.
module tb_demux_1xn_reg;

  localparam int DW   = 8;
  localparam int NCH  = 4;
  localparam int SW   = 2;
  localparam int NCH3 = 3;

  logic              clk;
  logic              rst;
  logic [DW-1:0]     a_data;
  logic              a_valid;
  logic [SW-1:0]     a_sel;
  logic              a_ready;
  logic [NCH*DW-1:0] o_data;
  logic [NCH-1:0]    o_valid;
  logic [NCH-1:0]    o_ready;
  logic              err_sel;
  logic [7:0]        drop_cnt;

  logic [DW-1:0]      b_data;
  logic               b_valid;
  logic [SW-1:0]      b_sel;
  logic               b_ready;
  logic [NCH3*DW-1:0] b_o_data;
  logic [NCH3-1:0]    b_o_valid;
  logic [NCH3-1:0]    b_o_ready;
  logic               b_err;
  logic [7:0]         b_drop;

`ifdef DEMUX_BROADCAST_EN
  logic a_bcast;
  logic b_bcast;
`endif

  int n_pass;
  int n_chk;
  logic [11:0] exp_q[$];

  demux_1xn_reg #(.DW(DW), .NCH(NCH)) u_dut (
    .clk      (clk),
    .rst      (rst),
`ifdef DEMUX_BROADCAST_EN
    .a_bcast  (a_bcast),
`endif
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_sel    (a_sel),
    .a_ready  (a_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .err_sel  (err_sel),
    .drop_cnt (drop_cnt)
  );

  demux_1xn_reg #(.DW(DW), .NCH(NCH3)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
`ifdef DEMUX_BROADCAST_EN
    .a_bcast  (b_bcast),
`endif
    .a_data   (b_data),
    .a_valid  (b_valid),
    .a_sel    (b_sel),
    .a_ready  (b_ready),
    .o_data   (b_o_data),
    .o_valid  (b_o_valid),
    .o_ready  (b_o_ready),
    .err_sel  (b_err),
    .drop_cnt (b_drop)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one unicast beat from posedge+1; returns the number of stalled cycles.
  task automatic drive_beat(input int sel, input logic [DW-1:0] data, output int waits);
    waits   = 0;
    a_valid = 1'b1;
    a_sel   = SW'(sel);
    a_data  = data;
    while (1) begin
      @(negedge clk);
      if (a_ready) begin
        exp_q.push_back({4'(sel), data});
        break;
      end
      waits++;
      if (waits > 50) begin
        n_chk++;
        $display("FAIL drive_timeout: a_ready low for %0d cycles, expected accept", waits);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  // Monitor: every completed channel transfer must match the queue head.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        if (o_valid[k] && o_ready[k]) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL mon_unexpected: ch%0d data 0x%0h, expected no output", k, o_data[k*DW +: DW]);
          end else begin
            e = exp_q.pop_front();
            check("mon_ch", k, {28'd0, e[11:8]});
            check("mon_data", {24'd0, o_data[k*DW +: DW]}, {24'd0, e[7:0]});
          end
        end
      end
    end
  end

  initial begin
    int w;
    int bad_v;
    int bad_r;
    int bad_e;
    n_pass = 0; n_chk = 0;
    rst = 1'b0; a_data = '0; a_valid = 1'b0; a_sel = '0; o_ready = '0;
    b_data = '0; b_valid = 1'b0; b_sel = '0; b_o_ready = '1;
`ifdef DEMUX_BROADCAST_EN
    a_bcast = 1'b0; b_bcast = 1'b0;
`endif
    #2 rst = 1'b1;
    #1;
    check("rst_o_valid", {28'd0, o_valid}, 0);
    check("rst_o_data", o_data, 0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 0);
    check("rst_err_sel", {31'd0, err_sel}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Unicast to channel 2
    o_ready = 4'hF;
    drive_beat(2, 8'hA5, w);
    check("t1_wait", w, 0);
    @(negedge clk);
    check("t1_o_valid", {28'd0, o_valid}, 32'h4);
    check("t1_slice2", {24'd0, o_data[23:16]}, 32'hA5);
    @(negedge clk);
    check("t1_o_valid_after", {28'd0, o_valid}, 0);
    @(posedge clk); #1;

    // Backpressure on channel 1
    o_ready = 4'b1101;
    drive_beat(1, 8'h11, w);
    check("t2_first_wait", w, 0);
    a_valid = 1'b1; a_sel = 2'd1; a_data = 8'h22;
    @(negedge clk);
    check("t2_ready_stall", {31'd0, a_ready}, 0);
    check("t2_hold1", {24'd0, o_data[15:8]}, 32'h11);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_ready_stall2", {31'd0, a_ready}, 0);
    check("t2_hold2", {24'd0, o_data[15:8]}, 32'h11);
    @(posedge clk); #1;
    o_ready = 4'hF;
    @(negedge clk);
    check("t2_ready_release", {31'd0, a_ready}, 1);
    if (a_ready) exp_q.push_back({4'd1, 8'h22});
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    check("t2_o_valid", {28'd0, o_valid}, 32'h2);
    check("t2_second", {24'd0, o_data[15:8]}, 32'h22);
    @(negedge clk);
    check("t2_o_valid_after", {28'd0, o_valid}, 0);
    @(posedge clk); #1;

    // Streaming to channel 0
    for (int i = 0; i < 10; i++) begin
      drive_beat(0, DW'(i), w);
      check("t3_no_stall", w, 0);
    end
    @(negedge clk);
    check("t3_last", {24'd0, o_data[7:0]}, 9);
    @(posedge clk); #1;

    // Out-of-range select on the 3-channel instance
    bad_v = 0; bad_r = 0; bad_e = 0;
    b_valid = 1'b1; b_sel = 2'd3; b_data = 8'hEE;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b_o_valid != 0) bad_v++;
      if (!b_ready) bad_r++;
      if (i >= 1 && !b_err) bad_e++;
      if (i == 0)   check("t4_err_first", {31'd0, b_err}, 0);
      if (i == 1)   check("t4_cnt1", {24'd0, b_drop}, 1);
      if (i == 254) check("t4_cnt254", {24'd0, b_drop}, 254);
      if (i == 255) check("t4_cnt255", {24'd0, b_drop}, 255);
      if (i == 299) check("t4_cnt_sat", {24'd0, b_drop}, 255);
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    check("t4_no_valid", bad_v, 0);
    check("t4_ready", bad_r, 0);
    check("t4_err_pulses", bad_e, 0);
    @(negedge clk);
    check("t4_err_last", {31'd0, b_err}, 1);
    check("t4_cnt_final", {24'd0, b_drop}, 255);
    @(negedge clk);
    check("t4_err_idle", {31'd0, b_err}, 0);
    @(posedge clk); #1;

    // Reset with channels 0 and 3 full
    o_ready = 4'h0;
    drive_beat(0, 8'h5A, w);
    drive_beat(3, 8'hC3, w);
    @(negedge clk);
    check("t5_full", {28'd0, o_valid}, 32'h9);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("t5_o_valid", {28'd0, o_valid}, 0);
    check("t5_o_data", o_data, 0);
    check("t5_drop_cnt", {24'd0, b_drop}, 0);
    check("t5_err", {31'd0, b_err}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    check("t5_hold_rst", {28'd0, o_valid}, 0);
    rst = 1'b0;
    o_ready = 4'hF;
    drive_beat(1, 8'h77, w);
    check("t5_first_accept", w, 0);
    @(negedge clk);
    check("t5_o_valid_post", {28'd0, o_valid}, 32'h2);
    check("t5_data_post", {24'd0, o_data[15:8]}, 32'h77);
    @(posedge clk); #1;

`ifdef DEMUX_BROADCAST_EN
    // Broadcast with channel 2 stalled full
    o_ready = 4'b1011;
    drive_beat(2, 8'h99, w);
    a_bcast = 1'b1; a_valid = 1'b1; a_sel = '0; a_data = 8'h3C;
    @(negedge clk);
    check("t6_stall", {31'd0, a_ready}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_stall2", {31'd0, a_ready}, 0);
    @(posedge clk); #1;
    o_ready = 4'hF;
    @(negedge clk);
    check("t6_ready", {31'd0, a_ready}, 1);
    if (a_ready) begin
      for (int k = 0; k < NCH; k++) exp_q.push_back({4'(k), 8'h3C});
    end
    @(posedge clk); #1;
    a_valid = 1'b0; a_bcast = 1'b0;
    @(negedge clk);
    check("t6_o_valid", {28'd0, o_valid}, 32'hF);
    check("t6_o_data", o_data, 32'h3C3C3C3C);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
